// File: rtl/cnn_conv3x3_if.sv
// Frame/weight/pixel handshake bundle for cnn_conv3x3_engine.
interface cnn_conv3x3_if #(
  parameter int WI    = 8,
  parameter int WW    = 8,
  parameter int IMG_W = 28,
  parameter int IMG_H = 28,
  parameter int NCH   = 4,
  parameter int ACCW  = 32
);
  localparam int AW = $clog2(NCH*9);

  logic                        iStart;
  logic                        iWeightWe;
  logic [AW-1:0]               iWeightAddr;
  logic signed [WW-1:0]        iWeightData;
  logic [WI-1:0]               iPixelIn;
  logic                        iPixelValid;
  logic                        oBusy;
  logic                        oValid;
  logic [NCH*ACCW-1:0]         oData;
  logic [$clog2(IMG_H)-1:0]    oRow;
  logic [$clog2(IMG_W)-1:0]    oCol;
  logic                        oFrameDone;

  modport slave (
    input  iStart, iWeightWe, iWeightAddr, iWeightData, iPixelIn, iPixelValid,
    output oBusy, oValid, oData, oRow, oCol, oFrameDone
  );

  modport master (
    output iStart, iWeightWe, iWeightAddr, iWeightData, iPixelIn, iPixelValid,
    input  oBusy, oValid, oData, oRow, oCol, oFrameDone
  );
endinterface

// File: rtl/cnn_conv3x3_engine.sv
// Streaming 3x3 valid convolution, NCH runtime-loaded signed kernels, frame control.
// Optional macro CNN_CONV_RELU_EN clamps negative channel results to zero at the output register.

// One channel: 9 products (stage 1) then exact adder tree (stage 2).
module cnn_conv3x3_ch #(
  parameter int WI   = 8,
  parameter int WW   = 8,
  parameter int ACCW = 32
) (
  input  logic                   clk_i,
  input  logic                   rst_n_i,
  input  logic [8:0][WI-1:0]     win_i,
  input  logic [8:0][WW-1:0]     wts_i,
  output logic [ACCW-1:0]        sum_o
);
  localparam int PW = WI + 1 + WW;

  logic signed [PW-1:0]   prod_q [9];
  logic signed [ACCW-1:0] sum_d;
  logic signed [ACCW-1:0] sum_q;

  always_ff @(posedge clk_i or negedge rst_n_i) begin
    if (!rst_n_i) begin
      for (int t = 0; t < 9; t++) prod_q[t] <= '0;
    end else begin
      for (int t = 0; t < 9; t++)
        prod_q[t] <= $signed({1'b0, win_i[t]}) * $signed(wts_i[t]);
    end
  end

  always_comb begin
    sum_d = '0;
    for (int t = 0; t < 9; t++) sum_d = sum_d + ACCW'(prod_q[t]);
  end

  always_ff @(posedge clk_i or negedge rst_n_i) begin
    if (!rst_n_i) sum_q <= '0;
    else          sum_q <= sum_d;
  end

  assign sum_o = sum_q;
endmodule

module cnn_conv3x3_engine #(
  parameter int WI    = 8,
  parameter int WW    = 8,
  parameter int IMG_W = 28,
  parameter int IMG_H = 28,
  parameter int NCH   = 4,
  parameter int ACCW  = 32
) (
  input  logic iClk,
  input  logic iRsn,
  cnn_conv3x3_if.slave bus
);
  localparam int AW     = $clog2(NCH*9);
  localparam int RW     = $clog2(IMG_H);
  localparam int CW     = $clog2(IMG_W);
  localparam int NW     = NCH*9;
  localparam int STAGES = 3;
  localparam logic [RW-1:0] ROW_LAST = RW'(IMG_H-1);
  localparam logic [CW-1:0] COL_LAST = CW'(IMG_W-1);

  typedef enum logic [1:0] {IDLE, RUN, DRAIN} state_e;
  typedef struct packed {
    logic [RW-1:0] row;
    logic [CW-1:0] col;
    logic          last;
  } tag_t;

  state_e                     state_q;
  logic                       busy_q;
  logic [RW-1:0]              row_q;
  logic [CW-1:0]              col_q;
  logic [NW-1:0][WW-1:0]      w_q;
  logic [IMG_W-1:0][WI-1:0]   lb0_q, lb1_q;
  logic [2:0][2:0][WI-1:0]    win_q, win_d;
  logic [STAGES:0]            vld_pipe;
  tag_t                       tag_pipe [STAGES];
  logic [NCH-1:0][ACCW-1:0]   sum_w;
  logic [NCH-1:0][ACCW-1:0]   data_q;
  logic [RW-1:0]              orow_q;
  logic [CW-1:0]              ocol_q;
  logic                       done_q;

  logic accept, last_px, win_vld;
  assign accept  = (state_q == RUN) && bus.iPixelValid;
  assign last_px = accept && (row_q == ROW_LAST) && (col_q == COL_LAST);
  assign win_vld = accept && (row_q >= RW'(2)) && (col_q >= CW'(2));

  // Frame FSM plus raster counters; busy is registered alongside the state.
  always_ff @(posedge iClk or negedge iRsn) begin
    if (!iRsn) begin
      state_q <= IDLE;
      busy_q  <= 1'b0;
      row_q   <= '0;
      col_q   <= '0;
    end else begin
      case (state_q)
        IDLE: if (bus.iStart) begin
          state_q <= RUN;
          busy_q  <= 1'b1;
          row_q   <= '0;
          col_q   <= '0;
        end
        RUN: begin
          if (accept) begin
            if (col_q == COL_LAST) begin
              col_q <= '0;
              row_q <= (row_q == ROW_LAST) ? '0 : row_q + RW'(1);
            end else begin
              col_q <= col_q + CW'(1);
            end
          end
          if (last_px) state_q <= DRAIN;
        end
        DRAIN: if (done_q) begin
          state_q <= IDLE;
          busy_q  <= 1'b0;
        end
        default: begin
          state_q <= IDLE;
          busy_q  <= 1'b0;
        end
      endcase
    end
  end

  always_ff @(posedge iClk or negedge iRsn) begin
    if (!iRsn)
      w_q <= '0;
    else if (state_q == IDLE && bus.iWeightWe && bus.iWeightAddr < AW'(NW))
      w_q[bus.iWeightAddr] <= bus.iWeightData;
  end

  // Window shifts left one column per accepted pixel; the new column is
  // {row r-2, row r-1, row r} at column c taken from the two line buffers.
  always_comb begin
    win_d = win_q;
    if (accept) begin
      for (int ky = 0; ky < 3; ky++) begin
        win_d[ky][0] = win_q[ky][1];
        win_d[ky][1] = win_q[ky][2];
      end
      win_d[0][2] = lb0_q[col_q];
      win_d[1][2] = lb1_q[col_q];
      win_d[2][2] = bus.iPixelIn;
    end
  end

  always_ff @(posedge iClk or negedge iRsn) begin
    if (!iRsn) begin
      lb0_q <= '0;
      lb1_q <= '0;
      win_q <= '0;
    end else begin
      win_q <= win_d;
      if (accept) begin
        lb0_q[col_q] <= lb1_q[col_q];
        lb1_q[col_q] <= bus.iPixelIn;
      end
    end
  end

  always_ff @(posedge iClk or negedge iRsn) begin
    if (!iRsn) begin
      vld_pipe <= '0;
      for (int s = 0; s < STAGES; s++) tag_pipe[s] <= '0;
    end else begin
      vld_pipe <= {vld_pipe[STAGES-1:0], win_vld};
      tag_pipe[0] <= '{row: row_q - RW'(2), col: col_q - CW'(2), last: last_px};
      for (int s = 1; s < STAGES; s++) tag_pipe[s] <= tag_pipe[s-1];
    end
  end

  for (genvar ch = 0; ch < NCH; ch++) begin : g_ch
    cnn_conv3x3_ch #(.WI(WI), .WW(WW), .ACCW(ACCW)) u_ch (
      .clk_i   (iClk),
      .rst_n_i (iRsn),
      .win_i   (win_q),
      .wts_i   (w_q[ch*9 +: 9]),
      .sum_o   (sum_w[ch])
    );
  end

  // Output stage holds its value between valid windows.
  always_ff @(posedge iClk or negedge iRsn) begin
    if (!iRsn) begin
      data_q <= '0;
      orow_q <= '0;
      ocol_q <= '0;
      done_q <= 1'b0;
    end else begin
      done_q <= vld_pipe[STAGES-1] && tag_pipe[STAGES-1].last;
      if (vld_pipe[STAGES-1]) begin
        orow_q <= tag_pipe[STAGES-1].row;
        ocol_q <= tag_pipe[STAGES-1].col;
        for (int ch = 0; ch < NCH; ch++) begin
`ifdef CNN_CONV_RELU_EN
          data_q[ch] <= sum_w[ch][ACCW-1] ? '0 : sum_w[ch];
`else
          data_q[ch] <= sum_w[ch];
`endif
        end
      end
    end
  end

  assign bus.oBusy      = busy_q;
  assign bus.oValid     = vld_pipe[STAGES];
  assign bus.oData      = data_q;
  assign bus.oRow       = orow_q;
  assign bus.oCol       = ocol_q;
  assign bus.oFrameDone = done_q;
endmodule

// File: doc/cnn_conv3x3_engine.md
Name: cnn_conv3x3_engine

Overview:
Parametrised successor of the single-bit, fixed four-kernel CNN front end. It takes a raster-scanned multi-bit pixel stream of configurable image size and builds the 3x3 window internally from two line buffers. It applies NCH runtime-loadable signed 3x3 kernels in parallel and emits one valid-convolution result per channel per window position. It adds frame control (start, busy, done), which the previous generation lacked, and sits between the pixel source and the pooling/FC stages.

Parameters:
WI, 8, unsigned pixel width
WW, 8, signed two's-complement weight width
IMG_W, 28, image width in pixels (>=3)
IMG_H, 28, image height in rows (>=3)
NCH, 4, number of parallel output channels (kernels)
ACCW, 32, signed accumulator/output width per channel (>= WI+WW+5)

Ports:
iClk  in  1  clock, rising edge
iRsn  in  1  asynchronous active-low reset
iStart  in  1  one-cycle frame start request
iWeightWe  in  1  weight write strobe
iWeightAddr  in  $clog2(NCH*9)  weight index = ch*9 + ky*3 + kx
iWeightData  in  WW  signed weight value
iPixelIn  in  WI  unsigned pixel, raster order
iPixelValid  in  1  pixel qualifier
oBusy  out  1  high in RUN or DRAIN
oValid  out  1  result qualifier, common to all channels
oData  out  NCH*ACCW  channel ch at bits [ch*ACCW +: ACCW], signed
oRow  out  $clog2(IMG_H)  output row index 0..IMG_H-3
oCol  out  $clog2(IMG_W)  output column index 0..IMG_W-3
oFrameDone  out  1  one-cycle pulse with the last oValid of a frame

Behaviour:
- Reset (async assert, sync release): state IDLE; oBusy, oValid, oFrameDone = 0; oData, oRow, oCol = 0; all weights = 0; line buffers, column/row counters and pipeline valids cleared.
- FSM IDLE -> RUN on iStart. RUN -> DRAIN when the pixel IMG_W*IMG_H is accepted. DRAIN -> IDLE on the cycle oFrameDone is asserted.
- Weight writes take effect only in IDLE, one write per cycle, visible from the next cycle. Writes in RUN/DRAIN and addresses >= NCH*9 are ignored.
- iStart in RUN/DRAIN is ignored. iPixelValid in IDLE/DRAIN is ignored.
- Pixel acceptance: iPixelValid high in RUN. Column counter wraps IMG_W-1 -> 0 and increments the row. Gaps (iPixelValid low) are allowed and stall only the counters and line buffers. The pipeline always advances.
- Window: kernel tap (ky,kx) multiplies the pixel at image (r-2+ky, c-2+kx), where (r,c) is the accepted pixel. A window is valid iff r>=2 and c>=2. There is no padding, so (IMG_H-2)*(IMG_W-2) results are produced per frame.
- Arithmetic: pixel zero-extended to WI+1 signed, multiplied by the signed weight. The 9 products are sign-extended to ACCW and summed exactly, with no saturation.
- Pipeline: stage 1 registers products, stage 2 registers the adder tree, stage 3 registers outputs. oValid rises 3 cycles after the accepting edge and is high for exactly 1 cycle per window. oRow = r-2 and oCol = c-2 are carried alongside.
- oData, oRow and oCol hold their last value while oValid is low.
- oFrameDone is asserted together with the oValid for (IMG_H-3, IMG_W-3). oBusy drops the following cycle.
- Reset mid-frame: everything returns to reset state, including weights, and partial outputs are discarded.
- A new iStart in the same cycle as the return to IDLE is not accepted. The earliest new start is the cycle after.

Optional Feature:
CNN_CONV_RELU_EN: when defined, each channel result is clamped to 0 if negative before the output register, so oData is never negative. When undefined, the raw signed sum is output. Latency is unchanged either way.

Test Plan:
- IMG_W=IMG_H=5, NCH=4; ch0 all weights 1; 25 pixels of value 1, back-to-back -> 9 oValid pulses, ch0=9, ch1..3=0, oRow/oCol sweep 0..2, oFrameDone with (2,2), first oValid 3 cycles after pixel (2,2).
- Identity kernel (ch1 tap (1,1)=1); pixel value = r*5+c -> ch1 result at (oRow,oCol) = (oRow+1)*5+(oCol+1), e.g. (0,0)=6, (2,2)=18.
- ch2 all weights -1, all pixels 255 -> ch2=-2295 (ACCW sign-extended); with CNN_CONV_RELU_EN -> 0.
- Random iPixelValid gaps (~50%) -> same results and order as back-to-back; no oValid during gaps beyond those from accepted pixels.
- Weight write and iStart during RUN -> ignored, results unchanged, oBusy stays high; a write in IDLE after the frame is used by the next frame.
- iRsn pulsed low mid-frame -> outputs 0 immediately, state IDLE, weights 0; next frame after reload completes correctly.
